// File: rtl/mmio_uart_bridge_if.sv
// Bus bundle between the CPU data port, data memory and the host UART
// channel. "slave" is the bridge view, "master" is the environment view.
interface mmio_uart_bridge_if #(
    parameter int DATA_MEM_DEPTH = 16
);
    logic [31:0]               cpu_dmem_addr;
    logic [31:0]               cpu_dmem_wdata;
    logic                      cpu_dmem_we;
    logic [31:0]               cpu_dmem_rdata;
    logic [DATA_MEM_DEPTH-1:0] mem_a;
    logic [31:0]               mem_d;
    logic                      mem_we;
    logic [31:0]               mem_spo;
    logic                      uart_tx_valid;
    logic [7:0]                uart_tx_data;
    logic                      uart_tx_ready;
    logic                      uart_rx_valid;
    logic [7:0]                uart_rx_data;
    logic                      uart_rx_ready;

    modport slave (
        input  cpu_dmem_addr, cpu_dmem_wdata, cpu_dmem_we,
        output cpu_dmem_rdata,
        output mem_a, mem_d, mem_we,
        input  mem_spo,
        output uart_tx_valid, uart_tx_data,
        input  uart_tx_ready,
        input  uart_rx_valid, uart_rx_data,
        output uart_rx_ready
    );

    modport master (
        output cpu_dmem_addr, cpu_dmem_wdata, cpu_dmem_we,
        input  cpu_dmem_rdata,
        input  mem_a, mem_d, mem_we,
        output mem_spo,
        input  uart_tx_valid, uart_tx_data,
        output uart_tx_ready,
        output uart_rx_valid, uart_rx_data,
        input  uart_rx_ready
    );
endinterface

// File: rtl/mmio_uart_bridge.sv
// MMIO decoder plus buffered UART. A 16-byte window holds TXDATA, RXDATA,
// STATUS and CTRL; every other CPU access passes straight to data memory.
module mmio_uart_bridge #(
    parameter logic [31:0] MMIO_BASE      = 32'hA000_03F0,
    parameter int          DATA_MEM_DEPTH = 16,
    parameter int          TX_DEPTH       = 8,
    parameter int          RX_DEPTH       = 8
) (
    input  logic                clk,
    input  logic                rst,
    mmio_uart_bridge_if.slave   bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    // ---------------- decode ----------------
    logic in_win;
    reg_e offset;
    logic win_we;

    assign in_win = (bus.cpu_dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign offset = reg_e'(bus.cpu_dmem_addr[3:2]);
    assign win_we = bus.cpu_dmem_we & in_win;

    assign bus.mem_a  = bus.cpu_dmem_addr[DATA_MEM_DEPTH+1:2];
    assign bus.mem_d  = bus.cpu_dmem_wdata;
    assign bus.mem_we = bus.cpu_dmem_we & ~in_win;

    // Byte lane bits are deliberately ignored inside the window.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cpu_dmem_addr[1:0];

    // ---------------- FIFO state ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             tx_drop;

    logic tx_full, tx_empty, rx_full, rx_empty;
    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);

    // ---------------- events ----------------
    logic tx_push_req, tx_push, tx_pop, tx_drop_set;
    logic ctrl_we, rx_pop, drop_clr, tx_flush, rx_flush, rx_push;

    assign tx_push_req = win_we && (offset == REG_TXDATA);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_drop_set = tx_push_req & tx_full;
    assign ctrl_we     = win_we && (offset == REG_CTRL);
    assign rx_pop      = ctrl_we & bus.cpu_dmem_wdata[0] & ~rx_empty;
    assign drop_clr    = ctrl_we & bus.cpu_dmem_wdata[1];
    assign tx_flush    = ctrl_we & bus.cpu_dmem_wdata[2];
    assign rx_flush    = ctrl_we & bus.cpu_dmem_wdata[3];

    assign bus.uart_tx_valid = ~tx_empty & ~rst;
    assign bus.uart_tx_data  = tx_mem[tx_rd_ptr];
    assign bus.uart_rx_ready = ~rx_full & ~rst;
    assign tx_pop  = bus.uart_tx_valid & bus.uart_tx_ready;
    assign rx_push = bus.uart_rx_valid & bus.uart_rx_ready;

    // TX pointers and occupancy; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst || tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // TX storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset; pointers and counts decide
        // which entries are meaningful, so stale data is never observed.
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.cpu_dmem_wdata[7:0];
    end

    // RX pointers and occupancy; flush overrides any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // RX storage write port.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.uart_rx_data;
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst)              tx_drop <= 1'b0;
        else if (tx_drop_set) tx_drop <= 1'b1;
        else if (drop_clr)    tx_drop <= 1'b0;
    end

    // ---------------- read mux ----------------
    logic [31:0] status;
    assign status = {8'h00, 8'(tx_count), 8'(rx_count), 4'h0,
                     tx_drop, tx_empty, tx_full, ~rx_empty};

    // CPU read data: memory outside the window, register file inside.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned, which would infer a latch.
        bus.cpu_dmem_rdata = bus.mem_spo;
        if (in_win) begin
            case (offset)
                REG_RXDATA: bus.cpu_dmem_rdata = rx_empty ? 32'h0
                                               : {24'h0, rx_mem[rx_rd_ptr]};
                REG_STATUS: bus.cpu_dmem_rdata = status;
                default:    bus.cpu_dmem_rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
- Parametrised MMIO decoder and buffered UART between the CPU data port, data memory and the simulator host UART channel.
- Replaces the single-register UART mapping with TX/RX FIFOs, a status register and a control register.
- Uses ready/valid handshakes on the host side.
- Every CPU data access outside the 16-byte MMIO window passes through to data memory unchanged.

Parameters:
- MMIO_BASE, 32'HA00003F0, base of the 16-byte MMIO window; must be 16-byte aligned.
- DATA_MEM_DEPTH, 16, word-address width of data memory.
- TX_DEPTH, 8, TX FIFO entries; power of two, 2..128.
- RX_DEPTH, 8, RX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_dmem_addr  in  32  CPU byte address.
- cpu_dmem_wdata  in  32  CPU write data.
- cpu_dmem_we  in  1  CPU write enable.
- cpu_dmem_rdata  out  32  read data returned to the CPU (combinational).
- mem_a  out  DATA_MEM_DEPTH  data memory word address = cpu_dmem_addr[DATA_MEM_DEPTH+1:2].
- mem_d  out  32  data memory write data = cpu_dmem_wdata.
- mem_we  out  1  data memory write enable.
- mem_spo  in  32  data memory read data.
- uart_tx_valid  out  1  TX byte available to the host.
- uart_tx_data  out  8  TX FIFO head byte.
- uart_tx_ready  in  1  host accepts the TX byte.
- uart_rx_valid  in  1  host offers an RX byte.
- uart_rx_data  in  8  RX byte from the host.
- uart_rx_ready  out  1  bridge accepts the RX byte.

Behaviour:
- Decode: in_win = (cpu_dmem_addr[31:4] == MMIO_BASE[31:4]). Register offset = addr[3:2]; addr[1:0] ignored.
- Memory side: mem_we = cpu_dmem_we & !in_win.
- Read mux, when !in_win: cpu_dmem_rdata = mem_spo.
- Read mux, when in_win:
  - offset 0: TXDATA, reads 0.
  - offset 1: RXDATA, {24'h0, RX head}, or 0 if RX empty.
  - offset 2: STATUS = {8'h0, tx_count, rx_count, 4'h0, tx_drop, tx_empty, tx_full, rx_nonempty}, with bit0 = rx_nonempty. Counts are zero-extended to 8 bits.
  - offset 3: CTRL, reads 0.
- Writes inside the window act on the rising clk edge:
  - offset 0: push wdata[7:0] into TX if !tx_full. If tx_full, the byte is discarded and sticky tx_drop is set.
  - offset 1: ignored.
  - offset 2: ignored.
  - offset 3 (CTRL) bits:
    - bit0: pop RX head; ignored if RX empty.
    - bit1: clear tx_drop.
    - bit2: flush TX.
    - bit3: flush RX.
    - All bits set together act together.
- TX host side:
  - uart_tx_valid = !tx_empty & !rst; uart_tx_data = TX head.
  - A byte transfers and pops on a clk edge with valid & ready.
  - The host may deassert ready at any time; data is held stable while valid & !ready.
- RX host side:
  - uart_rx_ready = !rx_full & !rst.
  - A byte pushes on an edge with valid & ready.
  - The host holds its byte while ready is low, so no RX overflow exists.
- FIFOs: circular buffers with read/write pointers and counts of width clog2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
  - Pointers wrap modulo DEPTH.
  - FIFO order is strict.
- Simultaneous events:
  - Push and pop in the same cycle: both occur and the count is unchanged. Full/empty are judged on the pre-edge state, so a push to a full FIFO is rejected even if a pop happens that cycle.
  - Flush in the same cycle as a push or pop: flush wins. Count and pointers go to 0 and the push is lost; a discarded TX push still sets tx_drop if the FIFO was full.
  - CTRL bit1 with a dropped push in the same cycle: set wins.
  - CPU RX pop together with a host RX push: both occur.
- Latency:
  - A pushed TX byte is visible on uart_tx_valid the cycle after the write edge.
  - A received RX byte is visible in RXDATA/STATUS the cycle after the handshake edge.
- Reset: all pointers, counts and tx_drop are cleared to 0.
  - During reset, uart_tx_valid = 0 and uart_rx_ready = 0.
  - After reset, STATUS = 32'h0000_0004 (tx_empty), uart_rx_ready = 1.
  - Reset mid-transfer discards all buffered bytes.
  - FIFO storage contents need not be reset.

Test Plan:
- Passthrough: write 32'h1234_5678 to 32'h0000_0010 -> mem_we=1, mem_a=4, uart_tx_valid stays 0.
- Write to MMIO_BASE+0 -> mem_we=0.
- TX burst: tx_ready=0; CPU writes 0x41..0x48 (8 bytes) to MMIO_BASE+0 -> STATUS=32'h0008_0002 (tx_count=8, tx_full).
  - Ninth write 0x49 -> tx_drop set, STATUS bit3=1.
  - Then tx_ready=1 -> host receives 0x41..0x48 in order over 8 cycles, tx_empty=1.
- RX backpressure: host streams 0x00..0x09 with rx_valid=1 and no CPU pops -> rx_ready drops after 8 accepts, rx_count=8.
  - Read RXDATA -> 0x00.
  - CTRL write 1 -> RXDATA=0x01 and rx_ready=1 the next cycle; bytes 0x08, 0x09 arrive later in order.
- Wrap/simultaneous: keep TX at count 3 while pushing and popping every cycle for 20 cycles -> count stays 3 and the byte order is preserved across pointer wrap.
- Flush/precedence: CTRL write 4'b1110 with TX holding 5 bytes and tx_drop=1, plus a concurrent host RX push -> STATUS=32'h0000_0004.
- Reset mid-operation: assert rst for 1 cycle with both FIFOs non-empty -> uart_tx_valid=0 and uart_rx_ready=0 during reset; STATUS=32'h0000_0004 afterwards.
